// File: rtl/matvec8_stream_tx_if.sv
// Command and output-stream bundle between the matvec8 transmit block and its neighbours.
// Handshake: a word or command moves on a rising clk edge where valid && ready are both 1;
// the valid side keeps valid high and its payload stable until that edge, ready may change freely.
interface matvec8_stream_tx_if #(
  parameter int W      = 14,
  parameter int SLOT_W = 1
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_send_matrix;
  logic [SLOT_W-1:0] cmd_vec_slot;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_new_matrix;

  modport master (
    input  cmd_valid, cmd_send_matrix, cmd_vec_slot, out_ready,
    output cmd_ready, out_valid, out_data, out_new_matrix
  );

  modport slave (
    output cmd_valid, cmd_send_matrix, cmd_vec_slot, out_ready,
    input  cmd_ready, out_valid, out_data, out_new_matrix
  );
endinterface

// File: rtl/matvec8_stream_tx.sv
// Streams a stored NxN matrix plus one of VEC_SLOTS vectors (or the vector alone)
// into the matvec8 input port; the word store is loaded through a simple write port.
module matvec8_stream_tx #(
  parameter int  W         = 14,
  parameter int  N         = 8,
  parameter int  VEC_SLOTS = 2,
  parameter int  SLOT_W    = (VEC_SLOTS > 1) ? $clog2(VEC_SLOTS) : 1,
  localparam int DEPTH     = N*N + VEC_SLOTS*N,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_en,
  input  logic [AW-1:0]       ld_addr,
  input  logic [W-1:0]        ld_data,
  matvec8_stream_tx_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                cmd_err,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_MAT = 2'd1,
    SEND_VEC = 2'd2
  } state_t;

  localparam logic [AW-1:0]   MAT_WORDS = AW'(N*N);
  localparam logic [AW-1:0]   MAT_LAST  = AW'(N*N - 1);
  localparam logic [AW:0]     DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [SLOT_W:0] SLOTS_C   = (SLOT_W+1)'(VEC_SLOTS);

  logic [W-1:0]  store [DEPTH];

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [AW-1:0] vec_base, vec_last;
  logic [AW-1:0] cmd_base;
  logic          accept, slot_bad, fire, mat_end, vec_end;
  logic          load_word, new_matrix_nxt, done_nxt, err_nxt;
  logic          valid_q, new_matrix_q, done_q, err_q;
  logic [W-1:0]  data_q;

  assign accept   = bus.cmd_valid && (state == IDLE);
  assign slot_bad = {1'b0, bus.cmd_vec_slot} >= SLOTS_C;
  assign cmd_base = MAT_WORDS + AW'(bus.cmd_vec_slot) * AW'(N);
  assign fire     = valid_q && bus.out_ready;
  assign mat_end  = (ptr == MAT_LAST);
  assign vec_end  = (ptr == vec_last);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic: each region's last accepted word is the only way out of its state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !slot_bad)
          state_nxt = bus.cmd_send_matrix ? SEND_MAT : SEND_VEC;
      end
      SEND_MAT: if (fire && mat_end) state_nxt = SEND_VEC;
      SEND_VEC: if (fire && vec_end) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // output logic: decides which word is fetched next and the flag/pulse values
  always_comb begin
    ptr_nxt        = ptr;
    load_word      = 1'b0;
    new_matrix_nxt = new_matrix_q;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (slot_bad) begin
            err_nxt = 1'b1;
          end else begin
            load_word      = 1'b1;
            ptr_nxt        = bus.cmd_send_matrix ? '0 : cmd_base;
            new_matrix_nxt = bus.cmd_send_matrix;
          end
        end
      end
      SEND_MAT: begin
        if (fire) begin
          load_word      = 1'b1;
          new_matrix_nxt = 1'b0;
          ptr_nxt        = mat_end ? vec_base : ptr + AW'(1);
        end
      end
      SEND_VEC: begin
        if (fire) begin
          new_matrix_nxt = 1'b0;
          if (vec_end) begin
            done_nxt = 1'b1;
          end else begin
            load_word = 1'b1;
            ptr_nxt   = ptr + AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr          <= '0;
      vec_base     <= '0;
      vec_last     <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      new_matrix_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ptr          <= ptr_nxt;
      valid_q      <= (state_nxt != IDLE);
      new_matrix_q <= new_matrix_nxt;
      done_q       <= done_nxt;
      err_q        <= err_nxt;
      if (load_word) data_q <= store[ptr_nxt];
      // slot window latched at accept so the matrix->vector hop needs no extra cycle
      if (accept) begin
        vec_base <= cmd_base;
        vec_last <= cmd_base + AW'(N - 1);
      end
    end
  end

  // store survives reset; writes only land while idle and not on an accept edge
  always_ff @(posedge clk) begin
    if (ld_en && (state == IDLE) && !accept && ({1'b0, ld_addr} < DEPTH_C))
      store[ld_addr] <= ld_data;
  end

  assign bus.cmd_ready      = (state == IDLE);
  assign bus.out_valid      = valid_q;
  assign bus.out_data       = data_q;
  assign bus.out_new_matrix = new_matrix_q;
  assign busy               = (state != IDLE);
  assign done               = done_q;
  assign cmd_err            = err_q;
  assign state_dbg          = state;

  a_no_valid_in_idle: assert property (@(posedge clk) disable iff (!reset)
    (state == IDLE) |-> !valid_q);

  a_hold_when_stalled: assert property (@(posedge clk) disable iff (!reset)
    (valid_q && !bus.out_ready) |=> (valid_q && $stable(data_q) && $stable(new_matrix_q)));

  a_pulses_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(done_q && err_q));

endmodule
